// File: rtl/sum_1d_pkg.sv
// sum_1d_pkg: shared constants, FSM states and elaboration helpers for the 1-D window summer
package sum_1d_pkg;

    localparam logic PAD_ZERO = 1'b0;
    localparam logic PAD_REPL = 1'b1;

    typedef enum logic {SKIP, RUN} state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic bit ksz_ok(input int k);
        return k >= 3 && k <= 15 && k % 2 == 1;
    endfunction

endpackage

// File: rtl/sum_1d_chan.sv
// sum_1d_chan: one channel's tap register, edge-pad substitution and registered window sum
module sum_1d_chan
    import sum_1d_pkg::*;
#(
    parameter int KSZ = 3,
    parameter int DW  = 8,
    parameter int SW  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DW-1:0]    din,
    input  logic             in_line,
    input  logic             rise,
    input  logic             pad,
    input  logic [KSZ-1:0]   flags,
    output logic [SW-1:0]    sum
);

    localparam int R = (KSZ - 1) / 2;

    logic [KSZ-1:1][DW-1:0] taps;
    logic [KSZ-1:0][DW-1:0] wnd;
    logic [DW-1:0]          first_px;
    logic [DW-1:0]          last_px;
    logic [SW-1:0]          acc;

    assign wnd = {taps, din};

    // taps newer than the centre can only be invalid past the line end, older ones before its start
    always_comb begin
        acc = '0;
        for (int k = 0; k < KSZ; k++)
            acc = acc + SW'(flags[k] ? wnd[k] : pad != PAD_REPL ? '0 : k < R ? last_px : first_px);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            taps     <= '0;
            first_px <= '0;
            last_px  <= '0;
            sum      <= '0;
        end else begin
            taps <= wnd[KSZ-2:0];
            if (rise)
                first_px <= din;
            if (in_line)
                last_px <= din;
            sum <= acc;
        end
    end

endmodule

// File: rtl/sum_1d_multi.sv
// sum_1d_multi: centre-aligned KSZ-pixel horizontal sum over CH packed channels, latency (KSZ+1)/2
module sum_1d_multi
    import sum_1d_pkg::*;
#(
    parameter int  KSZ = 3,
    parameter int  DW  = 8,
    parameter int  CH  = 1,
    localparam int SW  = DW + clog2(KSZ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pad_mode,
    input  logic             din_vsync,
    input  logic             din_hsync,
    input  logic [CH*DW-1:0] din,
    output logic             dout_vsync,
    output logic             dout_hsync,
    output logic [CH*SW-1:0] dout
);

    localparam int R = (KSZ - 1) / 2;
    localparam int L = R + 1;

    if (!ksz_ok(KSZ)) begin : g_bad_ksz
        $error("sum_1d_multi: KSZ must be odd and within 3..15");
    end

    state_t                 state, state_n;
    logic                   in_line;
    logic                   rise;
    logic                   pad_q;
    logic [KSZ-1:1]         hp;
    logic [KSZ-1:0]         flags;
    logic [L-1:0]           vp;
    logic [CH-1:0][SW-1:0]  sums;

    // hp[k] is the gated line flag k cycles ago; it doubles as the per-tap validity and the hsync delay
    assign in_line    = din_hsync && state == RUN;
    assign flags      = {hp, in_line};
    assign rise       = in_line && !hp[1];
    assign dout_hsync = hp[L];
    assign dout_vsync = vp[L-1];

    always_comb state_n = (state == SKIP && !din_hsync) ? RUN : state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SKIP;
            hp    <= '0;
            vp    <= '0;
            pad_q <= PAD_ZERO;
        end else begin
            state <= state_n;
            hp    <= flags[KSZ-2:0];
            vp    <= {vp[L-2:0], din_vsync};
            if (rise)
                pad_q <= pad_mode;
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        sum_1d_chan #(.KSZ(KSZ), .DW(DW), .SW(SW)) u_chan (
            .clk     (clk),
            .rst     (rst),
            .din     (din[c*DW +: DW]),
            .in_line (in_line),
            .rise    (rise),
            .pad     (pad_q),
            .flags   (flags),
            .sum     (sums[c])
        );
        assign dout[c*SW +: SW] = dout_hsync ? sums[c] : '0;
    end

endmodule
